if_inst_aligner: RTL and testbench

//  Fetch-side aligner between the icache response port and ifu. It issues word-aligned

---
 rtl/if_inst_aligner_pkg.sv | 21 ++
 rtl/if_inst_aligner_hw_queue.sv | 57 +++++
 rtl/if_inst_aligner.sv | 137 +++++++++++++
 tb/tb_if_inst_aligner.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/if_inst_aligner_pkg.sv
// Shared definitions for the fetch-side instruction aligner.
//   XLEN          : datapath / address width
//   RESET_PC_DEF  : default fetch PC after reset
//   ifa_state_e   : aligner FSM state encoding
//   hw_is_32      : true when a halfword opens a 32-bit instruction
package if_inst_aligner_pkg;

  localparam int          XLEN         = 32;
  localparam logic [31:0] RESET_PC_DEF = 32'h3000_0000;

  typedef enum logic [1:0] {
    IFA_RUN       = 2'd0,
    IFA_WAIT      = 2'd1,
    IFA_FAULT_OUT = 2'd2
  } ifa_state_e;

  function automatic logic hw_is_32(input logic [15:0] hw);
    return hw[1:0] == 2'b11;
  endfunction

endpackage

// File: rtl/if_inst_aligner_hw_queue.sv
// Four-entry halfword shift queue. Entry 0 is the head.
//   clk, rst        : clock, async active-high reset
//   flush           : empty the queue (wins over push/pop)
//   push_n          : halfwords to append this cycle (0..2), push_d0 first
//   pop_n           : halfwords to drop from the head this cycle (0..2)
//   head0, head1    : the two oldest entries
//   count           : number of valid entries (0..4)
module if_inst_aligner_hw_queue (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic [1:0]  push_n,
  input  logic [15:0] push_d0,
  input  logic [15:0] push_d1,
  input  logic [1:0]  pop_n,
  output logic [15:0] head0,
  output logic [15:0] head1,
  output logic [2:0]  count
);

  logic [15:0] hw  [4];
  logic [15:0] nxt [4];
  logic [2:0]  cnt_p;
  logic [2:0]  cnt_n;

  // Pop shifts the survivors down first; pushed halfwords then land
  // right behind them, so push and pop may happen in the same cycle.
  always_comb begin
    cnt_p = count - {1'b0, pop_n};
    cnt_n = cnt_p + {1'b0, push_n};
    case (pop_n)
      2'd1:    nxt = '{hw[1], hw[2], hw[3], 16'h0};
      2'd2:    nxt = '{hw[2], hw[3], 16'h0, 16'h0};
      default: nxt = hw;
    endcase
    for (int i = 0; i < 4; i++) begin
      if (push_n != 2'd0 && cnt_p == 3'(i))         nxt[i] = push_d0;
      if (push_n == 2'd2 && cnt_p + 3'd1 == 3'(i))  nxt[i] = push_d1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= 3'd0;
      for (int i = 0; i < 4; i++) hw[i] <= 16'h0;
    end else if (flush) begin
      count <= 3'd0;
    end else begin
      count <= cnt_n;
      hw    <= nxt;
    end
  end

  assign head0 = hw[0];
  assign head1 = hw[1];

endmodule

// File: rtl/if_inst_aligner.sv
// Fetch-side aligner between the icache response port and the ifu.
// Issues word-aligned fetches, buffers halfwords and presents one raw
// instruction (RVC or 32-bit, possibly straddling words) per handshake.
//   clk, rst            : clock, async active-high reset
//   fetch_req_*         : word fetch request to the icache
//   fetch_resp_*        : one response (data or fault) per accepted request
//   redirect_*          : flush and restart at a new PC
//   inst_*              : instruction slot towards the ifu
//
// state         | meaning
// IFA_RUN       | no request outstanding; may issue one
// IFA_WAIT      | one request outstanding, waiting for its response
// IFA_FAULT_OUT | presenting a fetch fault at head_pc until redirect
module if_inst_aligner
  import if_inst_aligner_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter int          BUF_HW   = 4
) (
  input  logic            clk,
  input  logic            rst,
  output logic            fetch_req_valid_o,
  output logic [XLEN-1:0] fetch_req_addr_o,
  input  logic            fetch_req_ready_i,
  input  logic            fetch_resp_valid_i,
  input  logic [XLEN-1:0] fetch_resp_data_i,
  input  logic            fetch_resp_fault_i,
  input  logic            redirect_valid_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic            inst_valid_o,
  input  logic            inst_ready_i,
  output logic [XLEN-1:0] inst_addr_o,
  output logic [XLEN-1:0] inst_data_o,
  output logic            inst_fault_o
);

  // A new word may only be requested if its two halfwords always fit.
  localparam logic [2:0] REQ_MAX = 3'(BUF_HW - 2);

  ifa_state_e      state;
  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] head_pc;
  logic            skip_lo;
  logic            discard;
  logic            fault_pend;

  logic [15:0] head0, head1;
  logic [2:0]  count;
  logic        head_is_32, complete, fault_out;
  logic        req_fire, resp_take, push_ok, inst_fire;
  logic [1:0]  push_n, pop_n;
  logic        unused_pc_bit0;

  assign unused_pc_bit0 = redirect_pc_i[0];

  assign head_is_32 = hw_is_32(head0);
  assign complete   = (count >= 3'd2) || (count != 3'd0 && !head_is_32);
  assign fault_out  = (state == IFA_FAULT_OUT);

  assign inst_valid_o = complete || fault_out;
  assign inst_fault_o = fault_out;
  assign inst_addr_o  = head_pc;
  assign inst_data_o  = fault_out  ? 32'h0 :
                        head_is_32 ? {head1, head0} : {16'h0, head0};

  assign fetch_req_valid_o = (state == IFA_RUN) && (count <= REQ_MAX) && !fault_pend;
  assign fetch_req_addr_o  = fetch_pc;
  assign req_fire          = fetch_req_valid_o && fetch_req_ready_i;

  // A response coinciding with a redirect belongs to the old stream.
  assign resp_take = (state == IFA_WAIT) && fetch_resp_valid_i && !redirect_valid_i;
  assign push_ok   = resp_take && !discard && !fetch_resp_fault_i;
  assign push_n    = !push_ok ? 2'd0 : (skip_lo ? 2'd1 : 2'd2);

  assign inst_fire = complete && !fault_out && inst_ready_i && !redirect_valid_i;
  assign pop_n     = !inst_fire ? 2'd0 : (head_is_32 ? 2'd2 : 2'd1);

  if_inst_aligner_hw_queue u_queue (
    .clk     (clk),
    .rst     (rst),
    .flush   (redirect_valid_i),
    .push_n  (push_n),
    .push_d0 (skip_lo ? fetch_resp_data_i[31:16] : fetch_resp_data_i[15:0]),
    .push_d1 (fetch_resp_data_i[31:16]),
    .pop_n   (pop_n),
    .head0   (head0),
    .head1   (head1),
    .count   (count)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IFA_RUN;
      fetch_pc   <= RESET_PC & ~32'd3;
      head_pc    <= RESET_PC;
      skip_lo    <= RESET_PC[1];
      discard    <= 1'b0;
      fault_pend <= 1'b0;
    end else if (redirect_valid_i) begin
      head_pc    <= {redirect_pc_i[31:1], 1'b0};
      fetch_pc   <= {redirect_pc_i[31:2], 2'b00};
      skip_lo    <= redirect_pc_i[1];
      fault_pend <= 1'b0;
      // Still owed a response (old one not yet back, or one just accepted):
      // wait for it and throw it away.
      if ((state == IFA_WAIT && !fetch_resp_valid_i) || req_fire) begin
        state   <= IFA_WAIT;
        discard <= 1'b1;
      end else begin
        state   <= IFA_RUN;
        discard <= 1'b0;
      end
    end else begin
      if (inst_fire) head_pc <= head_pc + (head_is_32 ? 32'd4 : 32'd2);
      case (state)
        IFA_RUN: begin
          if (fault_pend && !complete) begin
            state <= IFA_FAULT_OUT;
          end else if (req_fire) begin
            state    <= IFA_WAIT;
            fetch_pc <= fetch_pc + 32'd4;
          end
        end
        IFA_WAIT: begin
          if (fetch_resp_valid_i) begin
            state <= IFA_RUN;
            if (discard)                 discard    <= 1'b0;
            else if (fetch_resp_fault_i) fault_pend <= 1'b1;
            else if (skip_lo)            skip_lo    <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_if_inst_aligner.sv
module tb_if_inst_aligner;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_req_valid_o;
  logic [31:0] fetch_req_addr_o;
  logic        fetch_req_ready_i;
  logic        fetch_resp_valid_i;
  logic [31:0] fetch_resp_data_i;
  logic        fetch_resp_fault_i;
  logic        redirect_valid_i;
  logic [31:0] redirect_pc_i;
  logic        inst_valid_o;
  logic        inst_ready_i;
  logic [31:0] inst_addr_o;
  logic [31:0] inst_data_o;
  logic        inst_fault_o;

  if_inst_aligner dut (
    .clk                (clk),
    .rst                (rst),
    .fetch_req_valid_o  (fetch_req_valid_o),
    .fetch_req_addr_o   (fetch_req_addr_o),
    .fetch_req_ready_i  (fetch_req_ready_i),
    .fetch_resp_valid_i (fetch_resp_valid_i),
    .fetch_resp_data_i  (fetch_resp_data_i),
    .fetch_resp_fault_i (fetch_resp_fault_i),
    .redirect_valid_i   (redirect_valid_i),
    .redirect_pc_i      (redirect_pc_i),
    .inst_valid_o       (inst_valid_o),
    .inst_ready_i       (inst_ready_i),
    .inst_addr_o        (inst_addr_o),
    .inst_data_o        (inst_data_o),
    .inst_fault_o       (inst_fault_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // icache model: word memory, one response resp_delay steps after accept
  logic [31:0] mem [logic [31:0]];
  logic [31:0] fault_addr = 32'hffff_ffff;
  int          resp_delay = 0;
  bit          pend       = 1'b0;
  logic [31:0] pend_addr;
  int          wcnt;
  int          fires      = 0;
  logic [31:0] last_fire;

  logic [31:0] got_addr [$];
  logic [31:0] got_data [$];
  logic        got_flt  [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic present(input logic [31:0] a);
    fetch_resp_valid_i = 1'b1;
    fetch_resp_data_i  = mem.exists(a) ? mem[a] : 32'h0001_0001;
    fetch_resp_fault_i = (a == fault_addr);
  endtask

  // One clock: sample at negedge, advance, update icache model after edge.
  task automatic step();
    bit          f;
    logic [31:0] fa;
    @(negedge clk);
    f  = fetch_req_valid_o && fetch_req_ready_i;
    fa = fetch_req_addr_o;
    if (inst_valid_o && inst_ready_i) begin
      got_addr.push_back(inst_addr_o);
      got_data.push_back(inst_data_o);
      got_flt.push_back(inst_fault_o);
    end
    @(posedge clk);
    #1;
    fetch_resp_valid_i = 1'b0;
    fetch_resp_fault_i = 1'b0;
    if (pend) begin
      if (wcnt == 0) begin
        present(pend_addr);
        pend = 1'b0;
      end else begin
        wcnt--;
      end
    end
    if (f) begin
      fires++;
      last_fire = fa;
      if (resp_delay == 0) present(fa);
      else begin
        pend      = 1'b1;
        pend_addr = fa;
        wcnt      = resp_delay - 1;
      end
    end
  endtask

  task automatic clear_got();
    got_addr.delete();
    got_data.delete();
    got_flt.delete();
  endtask

  task automatic redirect(input logic [31:0] pc);
    redirect_valid_i = 1'b1;
    redirect_pc_i    = pc;
    step();
    redirect_valid_i = 1'b0;
    clear_got();
  endtask

  task automatic run_until_got(input string tag, input int n, input int budget);
    for (int k = 0; k < budget && got_addr.size() < n; k++) step();
    chk({tag, "_count"}, 32'(got_addr.size() >= n), 32'd1);
  endtask

  task automatic wait_fire(input string tag, input int budget);
    int f0;
    f0 = fires;
    for (int k = 0; k < budget && fires == f0; k++) step();
    chk({tag, "_fired"}, 32'(fires != f0), 32'd1);
  endtask

  task automatic chk_emit(input int idx, input string tag, input logic [31:0] a,
                          input logic [31:0] d, input logic f);
    logic [31:0] oa, od;
    logic        of;
    oa = 'x; od = 'x; of = 'x;
    if (idx < got_addr.size()) begin
      oa = got_addr[idx];
      od = got_data[idx];
      of = got_flt[idx];
    end
    chk({tag, "_addr"}, oa, a);
    chk({tag, "_data"}, od, d);
    chk({tag, "_flt"}, {31'b0, of}, {31'b0, f});
  endtask

  initial begin
    int f0;
    rst                = 1'b1;
    fetch_req_ready_i  = 1'b1;
    fetch_resp_valid_i = 1'b0;
    fetch_resp_data_i  = 32'h0;
    fetch_resp_fault_i = 1'b0;
    redirect_valid_i   = 1'b0;
    redirect_pc_i      = 32'h0;
    inst_ready_i       = 1'b1;

    mem[32'h3000_0000] = 32'h0000_0013;
    mem[32'h3000_0004] = 32'h0001_0001;
    mem[32'h3000_0400] = 32'h0513_4501;
    mem[32'h3000_0404] = 32'h0001_00a5;
    mem[32'h3000_0104] = 32'h8082_1111;
    mem[32'h3000_0500] = 32'h0201_0101;
    mem[32'h3000_0504] = 32'h0401_0301;
    mem[32'h3000_0508] = 32'h0601_0501;
    mem[32'h3000_0600] = 32'h0513_4501;
    mem[32'h3000_0700] = 32'h0002_0001;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // 1: reset state and first fetch
    chk("rst_inst_valid", {31'b0, inst_valid_o}, 32'd0);
    chk("rst_inst_fault", {31'b0, inst_fault_o}, 32'd0);
    chk("rst_req_valid", {31'b0, fetch_req_valid_o}, 32'd1);
    chk("rst_req_addr", fetch_req_addr_o, 32'h3000_0000);
    step();
    chk("t1_wait_no_inst", {31'b0, inst_valid_o}, 32'd0);
    chk("t1_wait_no_req", {31'b0, fetch_req_valid_o}, 32'd0);
    step();
    chk("t1_lat_valid", {31'b0, inst_valid_o}, 32'd1);
    chk("t1_lat_addr", inst_addr_o, 32'h3000_0000);
    run_until_got("t1", 3, 20);
    chk_emit(0, "t1_e0", 32'h3000_0000, 32'h0000_0013, 1'b0);
    chk_emit(1, "t1_e1", 32'h3000_0004, 32'h0000_0001, 1'b0);
    chk_emit(2, "t1_e2", 32'h3000_0006, 32'h0000_0001, 1'b0);

    // 2: straddling 32-bit instruction
    resp_delay = 3;
    redirect(32'h3000_0400);
    run_until_got("t2a", 1, 30);
    chk("t2_straddle_wait", {31'b0, inst_valid_o}, 32'd0);
    chk("t2_straddle_pc", inst_addr_o, 32'h3000_0402);
    run_until_got("t2b", 3, 40);
    chk_emit(0, "t2_e0", 32'h3000_0400, 32'h0000_4501, 1'b0);
    chk_emit(1, "t2_e1", 32'h3000_0402, 32'h00a5_0513, 1'b0);
    chk_emit(2, "t2_e2", 32'h3000_0406, 32'h0000_0001, 1'b0);

    // 3: redirect to odd-halfword target while a request is outstanding
    wait_fire("t3_pre", 20);
    redirect(32'h3000_0106);
    chk("t3_discard_no_req", {31'b0, fetch_req_valid_o}, 32'd0);
    wait_fire("t3_req", 20);
    chk("t3_req_addr", last_fire, 32'h3000_0104);
    run_until_got("t3", 2, 40);
    chk_emit(0, "t3_e0", 32'h3000_0106, 32'h0000_8082, 1'b0);
    chk_emit(1, "t3_e1", 32'h3000_0108, 32'h0000_0001, 1'b0);

    // 4: ifu stall with a full queue
    resp_delay   = 0;
    inst_ready_i = 1'b0;
    redirect(32'h3000_0500);
    repeat (12) step();
    chk("t4_full_no_req", {31'b0, fetch_req_valid_o}, 32'd0);
    chk("t4_hold_addr0", inst_addr_o, 32'h3000_0500);
    chk("t4_hold_data0", inst_data_o, 32'h0000_0101);
    f0 = fires;
    repeat (10) step();
    chk("t4_stall_fires", 32'(fires - f0), 32'd0);
    chk("t4_hold_valid", {31'b0, inst_valid_o}, 32'd1);
    chk("t4_hold_addr1", inst_addr_o, 32'h3000_0500);
    chk("t4_hold_data1", inst_data_o, 32'h0000_0101);
    inst_ready_i = 1'b1;
    run_until_got("t4", 6, 40);
    chk_emit(0, "t4_e0", 32'h3000_0500, 32'h0000_0101, 1'b0);
    chk_emit(1, "t4_e1", 32'h3000_0502, 32'h0000_0201, 1'b0);
    chk_emit(2, "t4_e2", 32'h3000_0504, 32'h0000_0301, 1'b0);
    chk_emit(3, "t4_e3", 32'h3000_0506, 32'h0000_0401, 1'b0);
    chk_emit(4, "t4_e4", 32'h3000_0508, 32'h0000_0501, 1'b0);
    chk_emit(5, "t4_e5", 32'h3000_050a, 32'h0000_0601, 1'b0);

    // 5: fault on the word completing a straddling head
    fault_addr = 32'h3000_0604;
    redirect(32'h3000_0600);
    run_until_got("t5", 2, 30);
    chk_emit(0, "t5_e0", 32'h3000_0600, 32'h0000_4501, 1'b0);
    chk_emit(1, "t5_flt", 32'h3000_0602, 32'h0000_0000, 1'b1);
    repeat (5) step();
    chk("t5_hold_valid", {31'b0, inst_valid_o}, 32'd1);
    chk("t5_hold_fault", {31'b0, inst_fault_o}, 32'd1);
    chk("t5_hold_addr", inst_addr_o, 32'h3000_0602);
    chk("t5_hold_data", inst_data_o, 32'h0);
    chk("t5_no_req", {31'b0, fetch_req_valid_o}, 32'd0);
    fault_addr = 32'hffff_ffff;
    redirect(32'h3000_0000);
    chk("t5_redir_fault", {31'b0, inst_fault_o}, 32'd0);
    chk("t5_redir_valid", {31'b0, inst_valid_o}, 32'd0);
    run_until_got("t5r", 1, 20);
    chk_emit(0, "t5_resume", 32'h3000_0000, 32'h0000_0013, 1'b0);

    // 6: redirect coinciding with a response
    resp_delay = 2;
    wait_fire("t6_pre", 20);
    for (int k = 0; k < 10 && !fetch_resp_valid_i; k++) step();
    chk("t6_resp_seen", {31'b0, fetch_resp_valid_i}, 32'd1);
    redirect(32'h3000_0700);
    chk("t6_empty", {31'b0, inst_valid_o}, 32'd0);
    chk("t6_req_valid", {31'b0, fetch_req_valid_o}, 32'd1);
    chk("t6_req_addr", fetch_req_addr_o, 32'h3000_0700);
    run_until_got("t6", 2, 30);
    chk_emit(0, "t6_e0", 32'h3000_0700, 32'h0000_0001, 1'b0);
    chk_emit(1, "t6_e1", 32'h3000_0702, 32'h0000_0002, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
